// File: rtl/i2c_master_byte_if.sv
// Command/status and pad-level bundle of the single-byte I2C master.
// The master modport is the controller's view; the slave modport is the
// host/pad side that drives commands and pad levels.
interface i2c_master_byte_if;
    logic       start;
    logic       rw;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       ack_err;
    logic       scl_oen;
    logic       sda_oen;
    logic       scl_i;
    logic       sda_i;

    modport master (
        input  start, rw, dev_addr, reg_addr, wdata, scl_i, sda_i,
        output busy, done, rdata, ack_err, scl_oen, sda_oen
    );

    modport slave (
        output start, rw, dev_addr, reg_addr, wdata, scl_i, sda_i,
        input  busy, done, rdata, ack_err, scl_oen, sda_oen
    );
endinterface

// File: rtl/i2c_master_byte.sv
// Single-register-access I2C master: write (ADDR_W, REG, WDATA) or read
// (ADDR_W, REG, repeated START, ADDR_R, RDATA). Every bit slot is four
// quarters of CLK_DIV clocks; the quarter counter freezes while a released
// SCL is held low by a slave (clock stretching). Pad enables are registered
// and released by the asynchronous reset.
module i2c_master_byte #(
    parameter int CLK_DIV = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    i2c_master_byte_if.master bus
);
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_BYTE, ST_RSTART, ST_STOP} state_t;
    typedef enum logic [2:0] {SEQ_ADDR_W, SEQ_REG, SEQ_WDATA, SEQ_ADDR_R, SEQ_RDATA} seq_t;

    localparam logic [9:0] QMAX = 10'(CLK_DIV - 1);

    state_t     r_state;
    seq_t       r_seq;
    logic [9:0] r_qcnt;
    logic [2:0] r_q;        // quarter inside the current state / bit slot
    logic [3:0] r_bit;      // bit slot 0..8, slot 8 is the ACK slot
    logic [7:0] r_tx;       // outgoing byte, shifted left and refilled with 1s
    logic [7:0] r_rx;
    logic       r_ack;
    logic       r_rw;
    logic [6:0] r_dev;
    logic [7:0] r_reg;
    logic [7:0] r_wdata;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_rdata;
    logic       r_ack_err;
    logic       r_scl_oen;
    logic       r_sda_oen;

    logic       w_hold;
    logic       w_tick;
    state_t     w_eob_state;
    seq_t       w_eob_seq;
    logic [7:0] w_eob_tx;
    logic       w_eob_err;

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.rdata   = r_rdata;
    assign bus.ack_err = r_ack_err;
    assign bus.scl_oen = r_scl_oen;
    assign bus.sda_oen = r_sda_oen;

    // Quarter timing: freeze while our released SCL is still held low, tick at the last clock of a quarter.
    always_comb begin
        w_hold = r_scl_oen & ~bus.scl_i;
        w_tick = ~w_hold & (r_qcnt == QMAX);
    end

    // Decide what follows a completed byte: next byte, repeated START or STOP.
    always_comb begin
        w_eob_state = ST_STOP;
        w_eob_seq   = r_seq;
        w_eob_tx    = 8'hFF;
        w_eob_err   = 1'b0;
        if ((r_seq != SEQ_RDATA) && r_ack) begin
            w_eob_err = 1'b1;
        end else begin
            case (r_seq)
                SEQ_ADDR_W: begin
                    w_eob_state = ST_BYTE;
                    w_eob_seq   = SEQ_REG;
                    w_eob_tx    = r_reg;
                end
                SEQ_REG: begin
                    if (r_rw) begin
                        w_eob_state = ST_RSTART;
                        w_eob_seq   = SEQ_ADDR_R;
                        w_eob_tx    = {r_dev, 1'b1};
                    end else begin
                        w_eob_state = ST_BYTE;
                        w_eob_seq   = SEQ_WDATA;
                        w_eob_tx    = r_wdata;
                    end
                end
                SEQ_ADDR_R: begin
                    w_eob_state = ST_BYTE;
                    w_eob_seq   = SEQ_RDATA;
                    w_eob_tx    = 8'hFF;
                end
                default: w_eob_state = ST_STOP;
            endcase
        end
    end

    // Command FSM: accept, START, nine-slot bytes, repeated START, STOP, done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_seq     <= SEQ_ADDR_W;
            r_qcnt    <= 10'd0;
            r_q       <= 3'd0;
            r_bit     <= 4'd0;
            r_tx      <= 8'h00;
            r_rx      <= 8'h00;
            r_ack     <= 1'b0;
            r_rw      <= 1'b0;
            r_dev     <= 7'h00;
            r_reg     <= 8'h00;
            r_wdata   <= 8'h00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rdata   <= 8'h00;
            r_ack_err <= 1'b0;
            r_scl_oen <= 1'b1;
            r_sda_oen <= 1'b1;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (bus.start && bus.scl_i && bus.sda_i) begin
                    r_rw      <= bus.rw;
                    r_dev     <= bus.dev_addr;
                    r_reg     <= bus.reg_addr;
                    r_wdata   <= bus.wdata;
                    r_tx      <= {bus.dev_addr, 1'b0};
                    r_seq     <= SEQ_ADDR_W;
                    r_busy    <= 1'b1;
                    r_ack_err <= 1'b0;
                    r_qcnt    <= 10'd0;
                    r_q       <= 3'd0;
                    r_bit     <= 4'd0;
                    r_scl_oen <= 1'b1;
                    r_sda_oen <= 1'b0;
                    r_state   <= ST_START;
                end
            end else begin
                if (!w_hold) begin
                    r_qcnt <= (r_qcnt == QMAX) ? 10'd0 : r_qcnt + 10'd1;
                end
                if (w_tick) begin
                    case (r_state)
                        ST_START: begin
                            if (r_q == 3'd1) begin
                                r_state   <= ST_BYTE;
                                r_q       <= 3'd0;
                                r_bit     <= 4'd0;
                                r_scl_oen <= 1'b0;
                                r_sda_oen <= r_tx[7];
                            end else begin
                                r_q <= r_q + 3'd1;
                            end
                        end
                        ST_BYTE: begin
                            case (r_q)
                                3'd0: r_q <= 3'd1;
                                3'd1: begin
                                    r_q       <= 3'd2;
                                    r_scl_oen <= 1'b1;
                                end
                                3'd2: begin
                                    r_q <= 3'd3;
                                    if (r_bit == 4'd8) begin
                                        r_ack <= bus.sda_i;
                                    end else begin
                                        r_rx <= {r_rx[6:0], bus.sda_i};
                                    end
                                end
                                3'd3: begin
                                    r_q       <= 3'd0;
                                    r_scl_oen <= 1'b0;
                                    if (r_bit != 4'd8) begin
                                        r_bit     <= r_bit + 4'd1;
                                        r_sda_oen <= r_tx[6];
                                        r_tx      <= {r_tx[6:0], 1'b1};
                                    end else begin
                                        r_state   <= w_eob_state;
                                        r_seq     <= w_eob_seq;
                                        r_tx      <= w_eob_tx;
                                        r_bit     <= 4'd0;
                                        r_sda_oen <= (w_eob_state == ST_BYTE) ? w_eob_tx[7]
                                                                              : (w_eob_state == ST_RSTART);
                                        if (w_eob_err) begin
                                            r_ack_err <= 1'b1;
                                        end
                                        if (r_seq == SEQ_RDATA) begin
                                            r_rdata <= r_rx;
                                        end
                                    end
                                end
                                default: r_q <= 3'd0;
                            endcase
                        end
                        ST_RSTART: begin
                            if (r_q == 3'd5) begin
                                r_state   <= ST_BYTE;
                                r_q       <= 3'd0;
                                r_bit     <= 4'd0;
                                r_scl_oen <= 1'b0;
                                r_sda_oen <= r_tx[7];
                            end else begin
                                r_q <= r_q + 3'd1;
                                if (r_q == 3'd1) begin
                                    r_scl_oen <= 1'b1;
                                end
                                if (r_q == 3'd3) begin
                                    r_sda_oen <= 1'b0;
                                end
                            end
                        end
                        ST_STOP: begin
                            if (r_q == 3'd5) begin
                                r_state <= ST_IDLE;
                                r_q     <= 3'd0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_q <= r_q + 3'd1;
                                if (r_q == 3'd1) begin
                                    r_scl_oen <= 1'b1;
                                end
                                if (r_q == 3'd3) begin
                                    r_sda_oen <= 1'b1;
                                end
                            end
                        end
                        default: begin
                            r_state   <= ST_IDLE;
                            r_busy    <= 1'b0;
                            r_scl_oen <= 1'b1;
                            r_sda_oen <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_master_byte.sv
// Directed bench for i2c_master_byte at CLK_DIV=25 with an oversampled
// I2C slave model at address 0x10 holding 16 registers (NACKs reg > 15).
module tb_i2c_master_byte;
    logic clk;
    logic rst_n;
    logic stretch;
    int   n_cmp;
    int   n_fail;
    int   cyc;
    int   t_acc;
    int   lat;
    int   poll_n;
    int   busy_cnt;

    i2c_master_byte_if bus ();

    i2c_master_byte #(.CLK_DIV(25)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Slave model state
    logic [7:0] mem [16] = '{default: 8'h00};
    logic       s_sda_oen = 1'b1;
    logic       p_scl = 1'b1;
    logic       p_sda = 1'b1;
    logic       c_scl;
    logic       c_sda;
    logic       s_act = 1'b0;
    logic       s_first = 1'b0;
    logic       s_tx = 1'b0;
    logic       s_rdmode = 1'b0;
    logic       s_mack = 1'b0;
    int         s_bit = 0;
    int         s_nbyte = 0;
    logic [7:0] s_sh = 8'h00;
    logic [3:0] s_ptr = 4'h0;

    assign bus.scl_i = bus.scl_oen & ~stretch;
    assign bus.sda_i = bus.sda_oen & s_sda_oen;

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter for latency measurement
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Oversampled slave: detects START/STOP, receives bytes, ACKs, serves reads
    always @(negedge clk) begin
        c_scl = bus.scl_i;
        c_sda = bus.sda_i;
        if (p_scl && c_scl && p_sda && !c_sda) begin
            s_act = 1'b1; s_first = 1'b1; s_bit = 0; s_nbyte = 0;
            s_tx = 1'b0; s_rdmode = 1'b0; s_sda_oen = 1'b1;
        end else if (p_scl && c_scl && !p_sda && c_sda) begin
            s_act = 1'b0; s_sda_oen = 1'b1;
        end else if (s_act) begin
            if (!p_scl && c_scl) begin
                if (s_bit < 8) begin
                    if (!s_tx) s_sh = {s_sh[6:0], c_sda};
                end else if (s_tx) begin
                    s_mack = c_sda;
                end
            end else if (p_scl && !c_scl) begin
                if (s_first) begin
                    s_first = 1'b0;
                end else if (s_bit < 7) begin
                    s_bit = s_bit + 1;
                    if (s_tx) s_sda_oen = s_sh[7 - s_bit];
                end else if (s_bit == 7) begin
                    s_bit = 8;
                    if (s_tx) begin
                        s_sda_oen = 1'b1;
                    end else if (s_nbyte == 0) begin
                        if (s_sh[7:1] == 7'h10) begin
                            s_sda_oen = 1'b0; s_rdmode = s_sh[0];
                        end else begin
                            s_act = 1'b0;
                        end
                    end else if (s_nbyte == 1) begin
                        if (s_sh < 8'd16) begin
                            s_sda_oen = 1'b0; s_ptr = s_sh[3:0];
                        end else begin
                            s_act = 1'b0;
                        end
                    end else begin
                        mem[s_ptr] = s_sh; s_ptr = s_ptr + 4'd1; s_sda_oen = 1'b0;
                    end
                end else begin
                    s_bit = 0;
                    if (s_tx) begin
                        s_tx = 1'b0; s_act = 1'b0; s_sda_oen = 1'b1;
                    end else if (s_nbyte == 0 && s_rdmode) begin
                        s_tx = 1'b1; s_sh = mem[s_ptr]; s_sda_oen = s_sh[7];
                    end else begin
                        s_sda_oen = 1'b1;
                    end
                    s_nbyte = s_nbyte + 1;
                end
            end
        end
        p_scl = c_scl;
        p_sda = c_sda;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_lat(input string tag, input int obs, input int exp);
        n_cmp++;
        assert ((obs >= exp - 1) && (obs <= exp + 1)) else begin
            n_fail++;
            $error("FAIL %s: observed %0d cycles expected %0d +-1", tag, obs, exp);
        end
    endtask

    task automatic issue_cmd(input logic i_rw, input logic [6:0] dev, input logic [7:0] ra,
                             input logic [7:0] wd, input int hold);
        int n;
        @(negedge clk);
        bus.rw = i_rw; bus.dev_addr = dev; bus.reg_addr = ra; bus.wdata = wd;
        if (hold > 0) begin
            stretch = 1'b1;
            bus.start = 1'b1;
            repeat (hold) @(posedge clk);
            #1;
            check("busy_while_bus_not_free", {31'd0, bus.busy}, 32'd0);
            stretch = 1'b0;
        end else begin
            bus.start = 1'b1;
        end
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus.busy && n < 200);
        bus.start = 1'b0;
        t_acc = cyc;
        check("accept", {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic wait_done(output int l);
        int n;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus.done && n < 20000);
        l = cyc - t_acc;
    endtask

    // Directed sequence
    initial begin
        n_cmp = 0; n_fail = 0; stretch = 1'b0; rst_n = 1'b0;
        bus.start = 1'b0; bus.rw = 1'b0; bus.dev_addr = 7'h00; bus.reg_addr = 8'h00; bus.wdata = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_busy",    {31'd0, bus.busy},    32'd0);
        check("rst_done",    {31'd0, bus.done},    32'd0);
        check("rst_rdata",   {24'd0, bus.rdata},   32'h00);
        check("rst_ack_err", {31'd0, bus.ack_err}, 32'd0);
        check("rst_scl_oen", {31'd0, bus.scl_oen}, 32'd1);
        check("rst_sda_oen", {31'd0, bus.sda_oen}, 32'd1);

        // 1: write 0xA5 to reg 2, start held while SCL low first
        issue_cmd(1'b0, 7'h10, 8'h02, 8'hA5, 5);
        wait_done(lat);
        check_lat("wr_latency", lat, 2900);
        check("wr_ack_err", {31'd0, bus.ack_err}, 32'd0);
        check("wr_busy_at_done", {31'd0, bus.busy}, 32'd0);
        check("wr_mem2", {24'd0, mem[2]}, 32'hA5);

        // 2: read reg 2 back
        issue_cmd(1'b1, 7'h10, 8'h02, 8'h00, 0);
        wait_done(lat);
        check_lat("rd_latency", lat, 3950);
        check("rd_rdata", {24'd0, bus.rdata}, 32'hA5);
        check("rd_ack_err", {31'd0, bus.ack_err}, 32'd0);
        check("rd_master_nack", {31'd0, s_mack}, 32'd1);

        // 3: wrong device address
        issue_cmd(1'b0, 7'h11, 8'h02, 8'h5A, 0);
        wait_done(lat);
        check_lat("nack_addr_latency", lat, 1100);
        check("nack_addr_ack_err", {31'd0, bus.ack_err}, 32'd1);
        check("nack_addr_mem2", {24'd0, mem[2]}, 32'hA5);

        // 4: register out of range
        issue_cmd(1'b0, 7'h10, 8'h20, 8'h33, 0);
        wait_done(lat);
        check_lat("nack_reg_latency", lat, 2000);
        check("nack_reg_ack_err", {31'd0, bus.ack_err}, 32'd1);

        // 5: 100 cycles of clock stretching in the first q2
        issue_cmd(1'b0, 7'h10, 8'h03, 8'h3C, 0);
        poll_n = 0;
        while (bus.scl_oen !== 1'b0 && poll_n < 1000) begin @(posedge clk); #1; poll_n++; end
        while (bus.scl_oen !== 1'b1 && poll_n < 2000) begin @(posedge clk); #1; poll_n++; end
        stretch = 1'b1;
        repeat (100) @(posedge clk);
        #1 stretch = 1'b0;
        wait_done(lat);
        check_lat("stretch_latency", lat, 3000);
        check("stretch_ack_err", {31'd0, bus.ack_err}, 32'd0);
        check("stretch_mem3", {24'd0, mem[3]}, 32'h3C);

        // 6a: start pulsed while busy is ignored
        issue_cmd(1'b0, 7'h10, 8'h04, 8'h11, 0);
        repeat (300) @(posedge clk);
        @(negedge clk);
        bus.reg_addr = 8'h05; bus.wdata = 8'hEE; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
        check_lat("busy_start_latency", lat, 2900);
        busy_cnt = 0;
        repeat (3000) begin @(posedge clk); #1; if (bus.busy) busy_cnt++; end
        check("no_second_transfer", busy_cnt, 32'd0);
        check("busy_start_mem4", {24'd0, mem[4]}, 32'h11);
        check("busy_start_mem5", {24'd0, mem[5]}, 32'h00);

        // 6b: asynchronous reset in the middle of the address byte
        issue_cmd(1'b0, 7'h10, 8'h06, 8'h77, 0);
        repeat (459) @(posedge clk);
        #1;
        check("pre_rst_scl_oen", {31'd0, bus.scl_oen}, 32'd0);
        check("pre_rst_sda_oen", {31'd0, bus.sda_oen}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_scl_oen", {31'd0, bus.scl_oen}, 32'd1);
        check("rst_mid_sda_oen", {31'd0, bus.sda_oen}, 32'd1);
        check("rst_mid_busy",    {31'd0, bus.busy},    32'd0);
        check("rst_mid_rdata",   {24'd0, bus.rdata},   32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
